// File: rtl/pipelined_adder.sv
// Segmented carry-ripple adder/subtractor with a valid/ready stage pipeline.
// Define PIPELINED_ADDER_SAT_EN to saturate Result on signed overflow.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sub,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             CarryOut,
   output logic             Overflow
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   // Handshake (both ports): a transfer happens on a rising edge where valid
   // and ready are both high; ready never depends on the same side's valid.

   logic [STAGES-1:0] st_v, st_c, nx_v, nx_c, ld;
   logic [WIDTH-1:0]  st_a [STAGES];
   logic [WIDTH-1:0]  st_b [STAGES];
   logic [WIDTH-1:0]  st_s [STAGES];
   logic [WIDTH-1:0]  nx_a [STAGES];
   logic [WIDTH-1:0]  nx_b [STAGES];
   logic [WIDTH-1:0]  nx_s [STAGES];
   logic              ovf;

   // Stage k can load unless it and every stage after it are full while the output stalls.
   always_comb begin : load_logic
      for (int k = 0; k < STAGES; k++)
         ld[k] = OutReady || !(&(st_v | ((STAGES'(1) << k) - STAGES'(1))));
   end

   always_comb begin : next_stage
      logic [WIDTH-1:0] pa, pb, ps;
      logic             pc, pv;
      logic [SEG:0]     seg;
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            pa = A;
            pb = Sub ? ~B : B;
            ps = '0;
            pc = Sub;
            pv = InValid;
         end else begin
            pa = st_a[(k == 0) ? 0 : k - 1];
            pb = st_b[(k == 0) ? 0 : k - 1];
            ps = st_s[(k == 0) ? 0 : k - 1];
            pc = st_c[(k == 0) ? 0 : k - 1];
            pv = st_v[(k == 0) ? 0 : k - 1];
         end
         seg = {1'b0, pa[k*SEG +: SEG]} + {1'b0, pb[k*SEG +: SEG]} + {{SEG{1'b0}}, pc};
         nx_a[k] = pa;
         nx_b[k] = pb;
         nx_s[k] = ps;
         nx_s[k][k*SEG +: SEG] = seg[SEG-1:0];
         nx_c[k] = seg[SEG];
         nx_v[k] = pv;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         st_v <= '0;
         st_c <= '0;
         for (int k = 0; k < STAGES; k++) begin
            st_a[k] <= '0;
            st_b[k] <= '0;
            st_s[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               st_v[k] <= nx_v[k];
               st_c[k] <= nx_c[k];
               st_a[k] <= nx_a[k];
               st_b[k] <= nx_b[k];
               st_s[k] <= nx_s[k];
            end
         end
      end
   end

   // st_b holds the already-inverted operand, so one sign rule covers add and subtract.
   assign ovf      = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                     (st_s[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
   assign InReady  = ld[0];
   assign OutValid = st_v[LAST];
   assign CarryOut = st_c[LAST];
   assign Overflow = ovf;

`ifdef PIPELINED_ADDER_SAT_EN
   assign Result = !ovf ? st_s[LAST] :
                   st_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign Result = st_s[LAST];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: scoreboard on a 32/4 instance,
// directed latency checks on 64/1 and 64/8 instances.
module tb_pipelined_adder;

   localparam int W = 32;
   localparam int S = 4;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
   logic [W-1:0] a, b, result;

   logic         v64, rdy1, rdy8, ov1, ov8, co1, co8, of1, of8;
   logic [63:0]  a64, b64, r1, r8;

   int           errors = 0;
   int           checks = 0;
   logic [W+1:0] exp_q [$];
   logic [W+1:0] e, stall_val;
   logic         stalled;
   logic         done;

   always #5 Clk = ~Clk;

   pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .Clk(Clk), .Reset(Reset), .InValid(in_valid), .InReady(in_ready),
      .A(a), .B(b), .Sub(sub), .OutValid(out_valid), .OutReady(out_ready),
      .Result(result), .CarryOut(carry_out), .Overflow(overflow));

   pipelined_adder #(.WIDTH(64), .STAGES(1)) u_d1 (
      .Clk(Clk), .Reset(Reset), .InValid(v64), .InReady(rdy1),
      .A(a64), .B(b64), .Sub(1'b1), .OutValid(ov1), .OutReady(1'b1),
      .Result(r1), .CarryOut(co1), .Overflow(of1));

   pipelined_adder #(.WIDTH(64), .STAGES(8)) u_d8 (
      .Clk(Clk), .Reset(Reset), .InValid(v64), .InReady(rdy8),
      .A(a64), .B(b64), .Sub(1'b1), .OutValid(ov8), .OutReady(1'b1),
      .Result(r8), .CarryOut(co8), .Overflow(of8));

   // Reference: {overflow, carry, result}
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
      logic [W:0]   full;
      logic [W-1:0] yy, r;
      logic         o;
      yy   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
      r    = full[W-1:0];
      o    = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
`ifdef PIPELINED_ADDER_SAT_EN
      if (o) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      return {o, full[W], r};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      int n;
      a = x; b = y; sub = s; in_valid = 1'b1;
      n = 0;
      @(negedge Clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge Clk);
      end
      if (n >= 200) check("send_timeout", 64'(in_ready), 64'(1));
      @(posedge Clk);
      #1;
   endtask

   // Monitor: inputs are stable at negedge, so handshakes for the next edge are known here.
   always @(negedge Clk) begin
      if (stalled) begin
         check("stall_valid", 64'(out_valid), 64'(1));
         check("stall_hold", 64'({overflow, carry_out, result}), 64'(stall_val));
         stalled = 1'b0;
      end
      if (Reset) begin
         exp_q.delete();
      end else begin
         check("in_ready", 64'(in_ready), 64'(out_ready || exp_q.size() != S));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("result", 64'(result), 64'(e[W-1:0]));
               check("carry", 64'(carry_out), 64'(e[W]));
               check("overflow", 64'(overflow), 64'(e[W+1]));
            end
         end
         if (out_valid && !out_ready) begin
            stalled   = 1'b1;
            stall_val = {overflow, carry_out, result};
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
      end
   end

   initial begin
      int lat, lat1, lat8, g;
      logic [64:0] res1, res8;
      Reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
      v64 = 1'b0; a64 = '0; b64 = '0; stalled = 1'b0; done = 1'b0;
      idle(3);
      Reset = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_result", 64'(result), 64'(0));
      check("rst_carry", 64'(carry_out), 64'(0));
      check("rst_overflow", 64'(overflow), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));

      // Latency on an empty pipeline
      send(32'h0000_0004, 32'h0040_0000, 1'b0);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         idle(1);
         lat++;
      end
      check("latency_32x4", 64'(lat), 64'(S));
      check("first_result", 64'(result), 64'h0040_0004);
      idle(2);

      // Carry ripple and signed overflow corners, back to back
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      send(32'h8000_0000, 32'h0000_0001, 1'b1);
      send(32'h0000_0000, 32'h0000_0001, 1'b1);
      in_valid = 1'b0;
      idle(1);
      send(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
      in_valid = 1'b0;
      idle(S + 2);

      // Fill while stalled, then consume and accept in the same cycle
      out_ready = 1'b0;
      for (int i = 0; i < S; i++) send(32'(i * 32'h1111_1111), 32'h0F0F_0F0F, i[0]);
      a = 32'hDEAD_BEEF; b = 32'h0000_0011; sub = 1'b0; in_valid = 1'b1;
      idle(3);
      check("full_in_ready", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      @(negedge Clk);
      check("swap_in_ready", 64'(in_ready), 64'(1));
      @(posedge Clk);
      #1;
      in_valid = 1'b0;
      idle(S + 2);

      // Random operands against a random output-ready pattern
      fork
         begin
            for (int i = 0; i < 16; i++)
               send($urandom, $urandom, 1'($urandom_range(0, 1)));
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            g = 0;
            while ((!done || exp_q.size() != 0) && g < 3000) begin
               idle(1);
               out_ready = 1'($urandom_range(0, 1));
               g++;
            end
            if (g >= 3000) check("drain_timeout", 64'(exp_q.size()), 64'(0));
            out_ready = 1'b1;
         end
      join
      idle(S + 2);

      // Reset with three operations in flight
      send(32'h0000_0001, 32'h0000_0001, 1'b0);
      send(32'h0000_0002, 32'h0000_0002, 1'b0);
      send(32'h0000_0003, 32'h0000_0003, 1'b0);
      in_valid = 1'b0;
      Reset = 1'b1;
      idle(1);
      Reset = 1'b0;
      check("post_rst_in_ready", 64'(in_ready), 64'(1));
      check("post_rst_valid0", 64'(out_valid), 64'(0));
      send(32'h0000_00A0, 32'h0000_000B, 1'b0);
      in_valid = 1'b0;
      for (int i = 1; i < S; i++) begin
         check("post_rst_quiet", 64'(out_valid), 64'(0));
         idle(1);
      end
      check("post_rst_first", 64'(out_valid), 64'(1));
      idle(2);

      // 64-bit subtract at depth 1 and depth 8
      a64 = 64'h0123_4567_89AB_CDEF;
      b64 = 64'h1111_1111_1111_1111;
      check("d1_in_ready", 64'(rdy1), 64'(1));
      check("d8_in_ready", 64'(rdy8), 64'(1));
      v64 = 1'b1;
      idle(1);
      v64 = 1'b0;
      lat = 1; lat1 = 0; lat8 = 0; res1 = '0; res8 = '0;
      repeat (12) begin
         if (ov1 && lat1 == 0) begin lat1 = lat; res1 = {co1, r1}; end
         if (ov8 && lat8 == 0) begin lat8 = lat; res8 = {co8, r8}; end
         idle(1);
         lat++;
      end
      check("latency_64x1", 64'(lat1), 64'(1));
      check("latency_64x8", 64'(lat8), 64'(8));
      check("d1_result", res1[63:0], 64'hF012_3456_789A_BCDE);
      check("d8_result", res8[63:0], 64'hF012_3456_789A_BCDE);
      check("d1_carry", 64'(res1[64]), 64'(0));
      check("d8_carry", 64'(res8[64]), 64'(0));

      check("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be legal for 8..64.
REQ-002 Parameter STAGES, default 4, pipeline depth; SHALL be legal for 1..8 with WIDTH % STAGES == 0.
REQ-003 Port Clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port InValid  input  1  operand set on A/B/Sub is presented.
REQ-006 Port InReady  output  1  block accepts the operand set this cycle.
REQ-007 Port A  input  WIDTH  first operand.
REQ-008 Port B  input  WIDTH  second operand.
REQ-009 Port Sub  input  1  0 = A+B, 1 = A-B.
REQ-010 Port OutValid  output  1  Result/flags hold a completed operation.
REQ-011 Port OutReady  input  1  downstream consumes the result this cycle.
REQ-012 Port Result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 Port CarryOut  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-014 Port Overflow  output  1  two's-complement signed overflow.

Function
REQ-015 Operand acceptance SHALL occur on a rising edge with InValid && InReady; exactly one operation per acceptance.
REQ-016 Subtract SHALL be computed as A + ~B + 1; add uses carry-in 0.
REQ-017 Operand SHALL be split into STAGES segments of WIDTH/STAGES bits; stage k SHALL add segment k (LSB first) with carry from stage k-1 and forward upper operand segments unchanged.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to OutValid when OutReady stays high.
REQ-019 Throughput SHALL be one operation per cycle when OutReady stays high.
REQ-020 Each stage SHALL load when empty or when the following stage (or output for the last) advances the same cycle.
REQ-021 InReady SHALL equal "stage 0 empty or stage 0 advances"; combinational from stage state and OutReady only, never from InValid.
REQ-022 While OutValid && !OutReady, Result, CarryOut, Overflow SHALL hold stable and no in-flight operation SHALL be lost or duplicated.
REQ-023 Pipeline full with OutReady low SHALL drive InReady low; operations SHALL emerge in acceptance order.
REQ-024 Overflow SHALL be 1 when operand signs (after B inversion for Sub) match and Result sign differs.
REQ-025 Bubbles (InValid low) SHALL propagate as empty stages and never raise OutValid.
REQ-026 Simultaneous output consume and input accept on a full pipeline SHALL both take effect in that cycle.

Reset
REQ-027 Reset high on a rising edge SHALL clear all stage valid bits, OutValid, Result, CarryOut and Overflow to 0.
REQ-028 Reset SHALL take precedence over acceptance; in-flight operations SHALL be discarded and never appear at the output.
REQ-029 InReady SHALL be 1 in the first cycle after Reset deasserts.

Configuration
REQ-030 Macro PIPELINED_ADDER_SAT_EN defined: on signed overflow Result SHALL saturate to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative); Overflow still reports 1; CarryOut unchanged.
REQ-031 Macro undefined: Result SHALL wrap modulo 2^WIDTH; no saturation logic SHALL be present.

Verification
REQ-032 WIDTH=32, STAGES=4: A=0x00000004, B=0x00400000, Sub=0, OutReady=1 -> Result=0x00400004, CarryOut=0, Overflow=0, OutValid exactly 4 cycles after acceptance.
REQ-033 A=0xFFFFFFFF, B=0x00000001, Sub=0 -> Result=0x00000000, CarryOut=1, Overflow=0 (carry rippled through all four stages).
REQ-034 A=0x7FFFFFFF, B=0x00000001, Sub=0 -> Overflow=1; Result=0x80000000 without macro, 0x7FFFFFFF with PIPELINED_ADDER_SAT_EN; A=0x80000000, B=1, Sub=1 -> Overflow=1, Result 0x7FFFFFFF / 0x80000000 (sat).
REQ-035 Back-to-back 16 random operations with OutReady toggled by a random pattern -> outputs match reference model in order, InReady low only when full and stalled, Result stable throughout every stall.
REQ-036 Three operations accepted, Reset pulsed one cycle at cycle 2 -> OutValid stays 0 for ≥STAGES cycles after reset, none of the three appear, first post-reset operand accepted next cycle.
REQ-037 STAGES=1 and STAGES=8 with WIDTH=64: A=0x0123456789ABCDEF, B=0x1111111111111111, Sub=1 -> Result=0xF0123456789ABCDE, CarryOut=0, latency 1 and 8 respectively.
